// File: rtl/comma_aligner_10b.sv
// comma_aligner_10b: finds K28.x comma boundaries in a 10-bit deserializer
// stream and emits word-aligned codewords with lock tracking.
//
// Ports:
//   clk            in   single clock
//   rst_n          in   synchronous active-low reset
//   raw_valid      in   raw_data carries a new deserializer word
//   raw_data[9:0]  in   unaligned word, bit 9 received first
//   codeword[9:0]  out  aligned codeword, bit 9 is line bit "a"
//   codeword_valid out  codeword is new this cycle
//   is_comma       out  codeword[9:3] holds a comma pattern
//   locked         out  alignment is locked
//   offset[3:0]    out  bit offset of the codeword inside {prev, raw}
module comma_aligner_10b #(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_valid,
    input  logic [9:0] raw_data,
    output logic [9:0] codeword,
    output logic       codeword_valid,
    output logic       is_comma,
    output logic       locked,
    output logic [3:0] offset
);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_e;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

    localparam logic [6:0] COMMA_N = 7'b0011111;
    localparam logic [6:0] COMMA_P = 7'b1100000;

    state_e     state_q, state_d;
    logic [9:0] prev_q;
    logic [3:0] offset_q, offset_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] miss_q, miss_d;
    logic [9:0] codeword_q;
    logic       valid_q;
    logic       is_comma_q;

    logic [19:0] window;
    logic [9:0]  cand [16];
    logic [15:0] comma_vec;
    logic [3:0]  hit_k;
    logic        any_hit;
    logic        on_offset;
    logic [3:0]  cnt_inc;
    logic [3:0]  miss_inc;

    // Oldest bit sits at window[19]; candidate k starts k bits into prev.
    assign window = {prev_q, raw_data};

    // Tables are padded to 16 entries so a 4-bit offset can index them
    // directly; entries 10..15 are never selected.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            cand[k] = '0;
        end
        for (int k = 0; k < 10; k++) begin
            cand[k] = window[19-k -: 10];
        end
    end

    always_comb begin
        comma_vec = '0;
        for (int k = 0; k < 10; k++) begin
            comma_vec[k] = (cand[k][9:3] == COMMA_N) ||
                           (cand[k][9:3] == COMMA_P);
        end
    end

    // Lowest-offset hit wins: scan downward so the last write is lowest k.
    always_comb begin
        hit_k = '0;
        for (int k = 9; k >= 0; k--) begin
            if (comma_vec[k]) begin
                hit_k = 4'(k);
            end
        end
    end

    assign any_hit   = |comma_vec;
    assign on_offset = comma_vec[offset_q];

    assign cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    assign miss_inc = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        cnt_d    = cnt_q;
        miss_d   = miss_q;
        if (raw_valid && any_hit) begin
            unique case (state_q)
                SEARCH: begin
                    offset_d = hit_k;
                    if (LOCK_N == 4'd1) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        state_d = VERIFY;
                        cnt_d   = 4'd1;
                    end
                end
                VERIFY: begin
                    if (on_offset) begin
                        if (cnt_inc >= LOCK_N) begin
                            state_d = LOCKED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        offset_d = hit_k;
                        cnt_d    = 4'd1;
                    end
                end
                LOCKED: begin
                    if (on_offset) begin
                        miss_d = '0;
                    end else if (miss_inc >= UNLOCK_N) begin
                        // Offset is kept so SEARCH restarts from a known point.
                        state_d = SEARCH;
                        miss_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SEARCH;
            prev_q     <= '0;
            offset_q   <= '0;
            cnt_q      <= '0;
            miss_q     <= '0;
            codeword_q <= '0;
            valid_q    <= 1'b0;
            is_comma_q <= 1'b0;
        end else begin
            valid_q <= raw_valid;
            if (raw_valid) begin
                state_q  <= state_d;
                prev_q   <= raw_data;
                offset_q <= offset_d;
                cnt_q    <= cnt_d;
                miss_q   <= miss_d;
                // Use the post-update offset so a realigning comma is
                // itself emitted aligned.
                codeword_q <= cand[offset_d];
                is_comma_q <= comma_vec[offset_d];
            end
        end
    end

    assign codeword       = codeword_q;
    assign codeword_valid = valid_q;
    assign is_comma       = is_comma_q;
    assign locked         = (state_q == LOCKED);
    assign offset         = offset_q;

endmodule

// File: tb/tb_comma_aligner_10b.sv
// tb_comma_aligner_10b: drives a serial bit line cut into 10-bit words and
// compares the aligner against a behavioural model every cycle.
module tb_comma_aligner_10b;

    localparam int LC = 4;
    localparam int UC = 4;

    localparam logic [9:0] KM = 10'b0011111010;
    localparam logic [9:0] KP = 10'b1100000101;
    localparam logic [9:0] DD = 10'b0101010101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       raw_valid;
    logic [9:0] raw_data;
    logic [9:0] codeword;
    logic       codeword_valid;
    logic       is_comma;
    logic       locked;
    logic [3:0] offset;

    always #5 clk = ~clk;

    comma_aligner_10b #(
        .LOCK_COUNT  (LC),
        .UNLOCK_COUNT(UC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .raw_valid     (raw_valid),
        .raw_data      (raw_data),
        .codeword      (codeword),
        .codeword_valid(codeword_valid),
        .is_comma      (is_comma),
        .locked        (locked),
        .offset        (offset)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 = hunting, 1 = confirming, 2 = locked.
    logic [9:0] m_prev;
    int         m_mode;
    int         m_cnt;
    int         m_miss;
    int         m_off;
    logic [9:0] m_cw;
    bit         m_cwv;
    bit         m_isc;

    function automatic bit has_comma(input logic [9:0] c);
        return (c[9:3] == 7'b0011111) || (c[9:3] == 7'b1100000);
    endfunction

    function automatic logic [9:0] slice_at(input logic [9:0] p,
                                            input logic [9:0] d,
                                            input int k);
        logic [19:0] w;
        w = {p, d};
        return 10'(w >> (10 - k));
    endfunction

    task automatic model_reset();
        m_prev = '0;
        m_mode = 0;
        m_cnt  = 0;
        m_miss = 0;
        m_off  = 0;
        m_cw   = '0;
        m_cwv  = 0;
        m_isc  = 0;
    endtask

    task automatic model_step(input bit v, input logic [9:0] d);
        int hk;
        bit here;
        if (!v) begin
            m_cwv = 0;
            return;
        end
        hk = -1;
        for (int k = 0; k < 10; k++) begin
            if (hk < 0 && has_comma(slice_at(m_prev, d, k))) hk = k;
        end
        here = has_comma(slice_at(m_prev, d, m_off));
        if (hk >= 0) begin
            if (m_mode == 0) begin
                m_off = hk;
                if (LC == 1) begin
                    m_mode = 2;
                    m_cnt  = 0;
                end else begin
                    m_mode = 1;
                    m_cnt  = 1;
                end
            end else if (m_mode == 1) begin
                if (here) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt >= LC) begin
                        m_mode = 2;
                        m_cnt  = 0;
                    end
                end else begin
                    m_off = hk;
                    m_cnt = 1;
                end
            end else begin
                if (here) begin
                    m_miss = 0;
                end else begin
                    m_miss = m_miss + 1;
                    if (m_miss >= UC) begin
                        m_mode = 0;
                        m_miss = 0;
                        m_cnt  = 0;
                    end
                end
            end
        end
        m_cw   = slice_at(m_prev, d, m_off);
        m_isc  = has_comma(m_cw);
        m_cwv  = 1;
        m_prev = d;
    endtask

    task automatic compare_outputs();
        chk("cw_valid", 32'(codeword_valid), 32'(m_cwv));
        if (m_cwv) begin
            chk("codeword", 32'(codeword), 32'(m_cw));
            chk("is_comma", 32'(is_comma), 32'(m_isc));
        end
        chk("locked", 32'(locked), 32'(m_mode == 2));
        chk("offset", 32'(offset), 32'(m_off));
    endtask

    task automatic send(input bit v, input logic [9:0] d);
        raw_valid = v;
        raw_data  = d;
        @(posedge clk);
        #1;
        model_step(v, d);
        compare_outputs();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        raw_valid = 1'b0;
        raw_data  = 10'($urandom);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk("rst_codeword", 32'(codeword), 32'd0);
        chk("rst_valid", 32'(codeword_valid), 32'd0);
        chk("rst_is_comma", 32'(is_comma), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_offset", 32'(offset), 32'd0);
    endtask

    // Serial line: bits are cut into raw words on 10-bit boundaries, so a
    // codeword starting at line position p shows up at offset p % 10.
    bit line[$];
    int pos       = 0;
    int idle_mode = 0;

    task automatic push_bits(input logic [9:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) line.push_back(w[i]);
        pos += n;
    endtask

    task automatic push_word(input logic [9:0] w);
        push_bits(w, 10);
    endtask

    task automatic filler(input int n);
        for (int i = 0; i < n; i++) line.push_back(bit'(i & 1));
        pos += n;
    endtask

    task automatic align_to(input int k);
        filler((k - (pos % 10) + 10) % 10);
    endtask

    task automatic drain();
        logic [9:0] w;
        while (line.size() >= 10) begin
            w = '0;
            for (int i = 0; i < 10; i++) w = {w[8:0], line.pop_front()};
            if (idle_mode == 2 && $urandom_range(0, 3) == 0)
                send(1'b0, 10'($urandom));
            send(1'b1, w);
            if (idle_mode == 1) begin
                send(1'b0, 10'($urandom));
                chk("idle_valid", 32'(codeword_valid), 32'd0);
            end
        end
    endtask

    // Pushes a comma plus one data word; the last word accepted is the
    // one whose window completes the comma.
    task automatic comma_now(input logic [9:0] k);
        push_word(k);
        push_word(DD);
        drain();
    endtask

    initial begin
        int r;
        rst_n     = 1'b0;
        raw_valid = 1'b0;
        raw_data  = '0;
        model_reset();
        do_reset();

        // Skew 3, comma every 8 words; lock on the 4th comma.
        filler(3);
        for (int g = 0; g < 5; g++) begin
            comma_now(KM);
            chk("skew3_offset", 32'(offset), 32'd3);
            chk("skew3_locked", 32'(locked), 32'(g >= 3));
            for (int i = 0; i < 6; i++) push_word(DD);
            drain();
        end

        // Three misaligned commas, then an aligned one clears misses.
        for (int i = 0; i < 3; i++) begin
            filler(3);
            comma_now(KM);
            chk("miss_hold_locked", 32'(locked), 32'd1);
            chk("miss_is_comma", 32'(is_comma), 32'd0);
            filler(7);
            push_word(DD);
            drain();
        end
        comma_now(KM);
        chk("miss_clear_locked", 32'(locked), 32'd1);
        chk("miss_clear_is_comma", 32'(is_comma), 32'd1);
        for (int i = 0; i < 4; i++) begin
            filler(3);
            comma_now(KM);
            chk("unlock_locked", 32'(locked), 32'(i < 3));
            chk("unlock_offset", 32'(offset), 32'd3);
            filler(7);
            push_word(DD);
            drain();
        end

        // Two confirmations at 3, then a comma at offset 7 realigns.
        comma_now(KM);
        comma_now(KM);
        chk("verify2_offset", 32'(offset), 32'd3);
        filler(4);
        comma_now(KM);
        chk("realign_offset", 32'(offset), 32'd7);
        chk("realign_is_comma", 32'(is_comma), 32'd1);
        chk("realign_codeword", 32'(codeword), 32'(KM));
        chk("realign_locked", 32'(locked), 32'd0);
        for (int i = 0; i < 3; i++) begin
            comma_now(KM);
            chk("relock7_locked", 32'(locked), 32'(i == 2));
            push_word(DD);
            push_word(DD);
            drain();
        end

        // Valid toggling over an aligned stream.
        idle_mode = 1;
        for (int i = 0; i < 16; i++) push_word((i % 8 == 0) ? KM : DD);
        drain();
        idle_mode = 0;
        chk("toggle_locked", 32'(locked), 32'd1);

        // Reset while locked; relock only on the 4th fresh comma.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            comma_now(KM);
            chk("post_rst_locked", 32'(locked), 32'(i == 3));
            chk("post_rst_offset", 32'(offset), 32'd7);
            for (int j = 0; j < 3; j++) push_word(DD);
            drain();
        end

        // Both polarities at the extreme offsets.
        for (int o = 0; o < 2; o++) begin
            for (int p = 0; p < 2; p++) begin
                do_reset();
                align_to(o * 9);
                push_word(DD);
                comma_now(p == 0 ? KM : KP);
                chk("edge_offset", 32'(offset), 32'(o * 9));
                chk("edge_is_comma", 32'(is_comma), 32'd1);
                chk("edge_codeword", 32'(codeword), 32'(p == 0 ? KM : KP));
            end
        end

        // Randomised traffic against the model.
        idle_mode = 2;
        for (int i = 0; i < 700; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) push_word(KM);
            else if (r < 25) push_word(KP);
            else if (r < 40) push_word(10'($urandom));
            else if (r < 45) push_bits(10'($urandom), int'($urandom_range(1, 9)));
            else if (r < 46) do_reset();
            else push_word(DD);
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/comma_aligner_10b.md
COMMA_ALIGNER_10B -- requirements
Module: comma_aligner_10b

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: number of consecutive same-offset commas needed to declare lock (range 1..15).
REQ-002 SHALL have parameter UNLOCK_COUNT, default 4: number of consecutive misaligned commas while locked that force loss of lock (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port raw_valid  input  1  raw_data holds a new deserializer word this cycle.
REQ-006 SHALL have port raw_data  input  10  unaligned deserializer word; bit 9 is received first.
REQ-007 SHALL have port codeword  output  10  aligned codeword for the downstream 8b/10b decoder; bit 9 is the first line bit ("a").
REQ-008 SHALL have port codeword_valid  output  1  codeword is new this cycle.
REQ-009 SHALL have port is_comma  output  1  codeword contains a comma in bits [9:3].
REQ-010 SHALL have port locked  output  1  alignment is locked.
REQ-011 SHALL have port offset  output  4  current bit offset, 0..9.

Function
REQ-012 SHALL keep prev[9:0], the last accepted raw_data, and form window[19:0] = {prev, raw_data}; window bit 19 is oldest.
REQ-013 SHALL define candidate(k), k=0..9, as window[19-k : 10-k].
REQ-014 SHALL flag comma(k) when candidate(k)[9:3] equals 7'b0011111 or 7'b1100000.
REQ-015 SHALL select hit_k as the lowest k with comma(k) set; any_hit is the OR of comma(0..9).
REQ-016 SHALL take no action on cycles with raw_valid=0: prev, FSM, counters and offset hold, and codeword_valid=0 on the next cycle.
REQ-017 SHALL implement FSM states SEARCH, VERIFY and LOCKED; locked=1 only in LOCKED.
REQ-018 In SEARCH, on an accepted word with any_hit: offset<=hit_k, count<=1, next state VERIFY, or LOCKED directly if LOCK_COUNT=1.
REQ-019 In VERIFY, on an accepted word with comma(offset): count increments; when the new count equals LOCK_COUNT, the FSM enters LOCKED and clears count.
REQ-020 In VERIFY, on an accepted word with any_hit but not comma(offset): offset<=hit_k, count<=1, state stays VERIFY.
REQ-021 In LOCKED, comma(offset) SHALL clear the miss counter.
REQ-022 In LOCKED, any_hit without comma(offset) SHALL increment the miss counter; on reaching UNLOCK_COUNT the FSM enters SEARCH, clears counters and leaves offset unchanged.
REQ-023 In any state, an accepted word with no comma SHALL leave FSM, counters and offset unchanged.
REQ-024 SHALL compute the effective offset for each accepted word as the offset after that word's update.
REQ-025 SHALL register codeword = candidate(effective offset) one cycle after acceptance with codeword_valid=1, so the comma that causes an offset change is itself emitted aligned (latency 1 cycle).
REQ-026 SHALL set is_comma to comma(effective offset), registered alongside codeword.
REQ-027 SHALL update locked and offset in the same cycle as the codeword they describe.
REQ-028 Counters SHALL be 4 bits and saturate; they SHALL never wrap.

Reset
REQ-029 When rst_n=0 at a clk edge, SHALL set prev=0, codeword=0, codeword_valid=0, is_comma=0, locked=0, offset=0, counters=0 and state=SEARCH.
REQ-030 Reset asserted mid-operation SHALL discard alignment; after release, lock requires LOCK_COUNT fresh commas.
REQ-031 The first accepted word after reset SHALL be aligned against prev=0, which contains no comma.

Verification
REQ-032 Stream of K28.5 (RD-: 0011111010) then D words, skewed by 3 bits, with comma every 8 words -> offset=3 after the first comma; locked=1 with the 4th comma; codeword equals the unskewed stream delayed 1 cycle.
REQ-033 While locked at offset 3, inject 3 commas at offset 6 then a comma at offset 3 -> locked stays 1 and the miss counter clears; inject 4 at offset 6 -> locked=0 on the 4th, state SEARCH.
REQ-034 In VERIFY with count=2 at offset 3, receive a comma at offset 7 -> offset=7, count=1, and that word is emitted aligned with is_comma=1.
REQ-035 raw_valid toggling 1/0 over an aligned stream -> codeword_valid mirrors raw_valid delayed 1 cycle; state and counters unchanged on idle cycles.
REQ-036 Assert rst_n=0 for 1 cycle while locked -> next cycle all outputs are 0; with LOCK_COUNT=4, relock only on the 4th subsequent comma.
REQ-037 Both comma polarities (0011111 and 1100000) at offset 0 and offset 9 -> detected at the correct offset, exercising window wrap across the prev/raw_data boundary.
